uart_tx: RTL and testbench

UART transmitter. It accepts a parallel byte with a one-cycle valid strobe and serializes it as one frame: start bit, data LSB-first, optional parity, stop bit. It sits on the TX side of the UART top and is the line-side counterpart of the receive path, whose stop check expects a high stop bit. It drives the serial line and a busy flag back to the data source.

---
 rtl/uart_tx_if.sv | 34 +++
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
// Connection bundle between a byte source and the UART transmitter.
//   P_DATA     : parallel byte to send (source -> tx)
//   DATA_VALID : one-cycle strobe qualifying P_DATA (source -> tx)
//   PAR_EN     : insert a parity bit (source -> tx)
//   PAR_TYP    : 0 even parity, 1 odd parity (source -> tx)
//   PRESCALE   : clock cycles per serial bit, 0 treated as 1 (source -> tx)
//   TX_OUT     : serial line, idles high (tx -> line/source)
//   busy       : frame in progress (tx -> source)
// master = byte source, slave = transmitter.
// ---------------------------------------------------------------------------
interface uart_tx_if #(
   parameter int BUS_WIDTH   = 8,
   parameter int PRESC_WIDTH = 6
);
   logic [BUS_WIDTH-1:0]   P_DATA;
   logic                   DATA_VALID;
   logic                   PAR_EN;
   logic                   PAR_TYP;
   logic [PRESC_WIDTH-1:0] PRESCALE;
   logic                   TX_OUT;
   logic                   busy;

   modport master (
      output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, PRESCALE,
      input  TX_OUT, busy
   );

   modport slave (
      input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, PRESCALE,
      output TX_OUT, busy
   );
endinterface

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: takes a byte on a one-cycle DATA_VALID strobe and sends
// start bit (0), data LSB first, optional parity, stop bit (1). Every bit is
// held for PRESCALE clock cycles (0 behaves as 1). Strobes arriving while a
// frame is in progress are dropped.
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-low reset
//   bus : uart_tx_if.slave (P_DATA, DATA_VALID, PAR_EN, PAR_TYP, PRESCALE in;
//         TX_OUT, busy out, both straight from flops)
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int BUS_WIDTH   = 8,
   parameter int PRESC_WIDTH = 6
) (
   input  logic     CLK,
   input  logic     RST,
   uart_tx_if.slave bus
);
   localparam int IDX_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 r_state,   w_state_next;
   logic [BUS_WIDTH-1:0]   r_shift,   w_shift_next;
   logic [IDX_W-1:0]       r_idx,     w_idx_next;
   logic [PRESC_WIDTH-1:0] r_presc,   w_presc_next;
   logic [PRESC_WIDTH-1:0] r_cnt,     w_cnt_next;
   logic                   r_par_en,  w_par_en_next;
   logic                   r_parity,  w_parity_next;
   logic                   r_tx,      w_tx_next;
   logic                   r_busy,    w_busy_next;

   logic [PRESC_WIDTH-1:0] w_presc_in;
   logic                   w_bit_done;

   assign w_presc_in = (bus.PRESCALE == '0) ? PRESC_WIDTH'(1) : bus.PRESCALE;
   assign w_bit_done = (r_cnt == (r_presc - PRESC_WIDTH'(1)));

   assign bus.TX_OUT = r_tx;
   assign bus.busy   = r_busy;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_idx    <= '0;
         r_presc  <= '0;
         r_cnt    <= '0;
         r_par_en <= 1'b0;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_shift  <= w_shift_next;
         r_idx    <= w_idx_next;
         r_presc  <= w_presc_next;
         r_cnt    <= w_cnt_next;
         r_par_en <= w_par_en_next;
         r_parity <= w_parity_next;
         r_tx     <= w_tx_next;
         r_busy   <= w_busy_next;
      end
   end

   // TX_OUT is registered, so the line value for a bit is loaded on the
   // same edge that enters that bit's state.
   always_comb begin
      w_state_next  = r_state;
      w_shift_next  = r_shift;
      w_idx_next    = r_idx;
      w_presc_next  = r_presc;
      w_cnt_next    = r_cnt;
      w_par_en_next = r_par_en;
      w_parity_next = r_parity;
      w_tx_next     = r_tx;
      w_busy_next   = r_busy;

      if (r_state != IDLE) begin
         w_cnt_next = w_bit_done ? '0 : r_cnt + PRESC_WIDTH'(1);
      end

      case (r_state)
         IDLE: begin
            w_tx_next   = 1'b1;
            w_busy_next = 1'b0;
            if (bus.DATA_VALID) begin
               w_shift_next  = bus.P_DATA;
               w_par_en_next = bus.PAR_EN;
               // Parity is resolved at capture; PAR_TYP flips even to odd.
               w_parity_next = (^bus.P_DATA) ^ bus.PAR_TYP;
               w_presc_next  = w_presc_in;
               w_cnt_next    = '0;
               w_idx_next    = '0;
               w_state_next  = START;
               w_tx_next     = 1'b0;
               w_busy_next   = 1'b1;
            end
         end
         START: begin
            if (w_bit_done) begin
               w_state_next = DATA;
               w_idx_next   = '0;
               w_tx_next    = r_shift[0];
            end
         end
         DATA: begin
            if (w_bit_done) begin
               if (r_idx == IDX_W'(BUS_WIDTH - 1)) begin
                  if (r_par_en) begin
                     w_state_next = PARITY;
                     w_tx_next    = r_parity;
                  end else begin
                     w_state_next = STOP;
                     w_tx_next    = 1'b1;
                  end
               end else begin
                  // Shift so the next data bit always sits at position 0.
                  w_shift_next = r_shift >> 1;
                  w_tx_next    = r_shift[1];
                  w_idx_next   = r_idx + IDX_W'(1);
               end
            end
         end
         PARITY: begin
            if (w_bit_done) begin
               w_state_next = STOP;
               w_tx_next    = 1'b1;
            end
         end
         STOP: begin
            if (w_bit_done) begin
               w_state_next = IDLE;
               w_tx_next    = 1'b1;
               w_busy_next  = 1'b0;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_tx_next    = 1'b1;
            w_busy_next  = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
   localparam int BW = 8;
   localparam int PW = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_if #(.BUS_WIDTH(BW), .PRESC_WIDTH(PW)) bus ();

   uart_tx #(.BUS_WIDTH(BW), .PRESC_WIDTH(PW)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   bit exp_q[$];
   bit mon_en   = 1'b0;
   int busy_cnt = 0;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       pt;
      logic [5:0] presc;
      int         exp_p;
      logic       exp_par;
      int         exp_cycles;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: one expected line value per busy cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.busy === 1'b1) begin
            busy_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL tx_extra_bit actual=%0b expected=no_bit t=%0t", bus.TX_OUT, $time);
            end else begin
               bit e;
               e = exp_q.pop_front();
               check("tx_bit", bus.TX_OUT, e);
            end
         end else begin
            check("tx_idle_high", bus.TX_OUT, 1);
         end
      end
   end

   task automatic push_frame(input logic [7:0] d, input logic pe, input logic par, input int p);
      repeat (p) exp_q.push_back(1'b0);
      for (int i = 0; i < BW; i++) repeat (p) exp_q.push_back(d[i]);
      if (pe) repeat (p) exp_q.push_back(par);
      repeat (p) exp_q.push_back(1'b1);
   endtask

   // Call just after a negedge; strobes DATA_VALID on the following posedge.
   task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] presc);
      bus.P_DATA     = d;
      bus.PAR_EN     = pe;
      bus.PAR_TYP    = pt;
      bus.PRESCALE   = presc;
      bus.DATA_VALID = 1'b1;
      busy_cnt       = 0;
      @(posedge clk);
      #1;
      check("start_latency_busy", bus.busy, 1);
      check("start_latency_tx", bus.TX_OUT, 0);
      @(negedge clk);
      bus.DATA_VALID = 1'b0;
      // Disturb every input mid-frame; the frame in flight must not notice.
      bus.P_DATA     = ~d;
      bus.PAR_EN     = ~pe;
      bus.PAR_TYP    = ~pt;
      bus.PRESCALE   = 6'd8;
   endtask

   task automatic wait_done(input string name, input int exp_cycles);
      int n = 0;
      while (bus.busy === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      #1;
      if (n >= 2000) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=busy_stuck expected=idle", name);
      end
      check({name, "_busy_cycles"}, busy_cnt, exp_cycles);
      check({name, "_queue_left"}, exp_q.size(), 0);
      $display("frame %s busy_cycles=%0d expected=%0d", name, busy_cnt, exp_cycles);
   endtask

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd1, 1, 1'b0, 10};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'd1, 1, 1'b0, 11};
      vecs[2] = '{8'hA5, 1'b1, 1'b1, 6'd1, 1, 1'b1, 11};
      vecs[3] = '{8'h01, 1'b1, 1'b0, 6'd4, 4, 1'b1, 44};
      vecs[4] = '{8'h3C, 1'b0, 1'b1, 6'd0, 1, 1'b0, 10};
      vecs[5] = '{8'h80, 1'b1, 1'b1, 6'd3, 3, 1'b0, 33};

      bus.P_DATA     = '0;
      bus.DATA_VALID = 1'b0;
      bus.PAR_EN     = 1'b0;
      bus.PAR_TYP    = 1'b0;
      bus.PRESCALE   = 6'd1;

      repeat (3) @(negedge clk);
      check("reset_tx", bus.TX_OUT, 1);
      check("reset_busy", bus.busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;

      for (int i = 0; i < 6; i++) begin
         push_frame(vecs[i].data, vecs[i].pe, vecs[i].exp_par, vecs[i].exp_p);
         @(negedge clk);
         send(vecs[i].data, vecs[i].pe, vecs[i].pt, vecs[i].presc);
         wait_done($sformatf("vec%0d", i), vecs[i].exp_cycles);
      end

      // Busy rejection: strobe 0x3C during the data bits of a 0xFF frame.
      push_frame(8'hFF, 1'b0, 1'b0, 2);
      @(negedge clk);
      send(8'hFF, 1'b0, 1'b0, 6'd2);
      repeat (5) @(negedge clk);
      bus.P_DATA     = 8'h3C;
      bus.PAR_EN     = 1'b0;
      bus.PRESCALE   = 6'd1;
      bus.DATA_VALID = 1'b1;
      @(negedge clk);
      bus.DATA_VALID = 1'b0;
      wait_done("reject", 20);
      repeat (12) begin
         @(negedge clk);
         #1;
         check("reject_no_second_frame", bus.busy, 0);
      end

      // Back-to-back: 0x55 offered on the first idle cycle, PRESCALE=0.
      push_frame(8'h33, 1'b0, 1'b0, 1);
      @(negedge clk);
      send(8'h33, 1'b0, 1'b0, 6'd1);
      wait_done("b2b_first", 10);
      check("b2b_idle_tx", bus.TX_OUT, 1);
      check("b2b_idle_busy", bus.busy, 0);
      push_frame(8'h55, 1'b0, 1'b0, 1);
      send(8'h55, 1'b0, 1'b0, 6'd0);
      wait_done("b2b_second", 10);

      // Reset in the middle of a start bit.
      @(negedge clk);
      mon_en = 1'b0;
      send(8'hC3, 1'b1, 1'b0, 6'd4);
      @(posedge clk);
      #2;
      check("mid_start_tx_before_reset", bus.TX_OUT, 0);
      rst_n = 1'b0;
      #1;
      check("async_reset_tx", bus.TX_OUT, 1);
      check("async_reset_busy", bus.busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      repeat (20) begin
         @(negedge clk);
         #1;
         check("post_reset_busy", bus.busy, 0);
         check("post_reset_tx", bus.TX_OUT, 1);
      end
      $display("frame reset_abort checked");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
